quad_enc_filter: RTL

Input conditioner for one quadrature encoder channel: synchronizes raw A/B/index pins, samples them on a programmable prescaler tick, and rejects glitches shorter than `FILT_LEN` consecutive samples. Outputs clean `quadA`/`quadB` levels and a single-cycle `index_strobe` that feed the quadrature encoder manager directly. Also flags illegal A/B transitions and counts them.

---
 rtl/quad_enc_filter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/quad_enc_filter.sv
// Quadrature encoder input conditioner: 2-FF sync, prescaled sampling, run-length glitch filter.
// Optional macro QUAD_ENC_FILT_INDEX_GATE_EN qualifies index_strobe with the {quadA,quadB} state.
module quad_enc_filter #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             quadA_i,
    input  logic             quadB_i,
    input  logic             index_i,
    input  logic [15:0]      clk_div_i,
    input  logic [1:0]       index_gate_i,
    input  logic             err_clr_i,
    output logic             quadA,
    output logic             quadB,
    output logic             index_strobe,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             err_sticky
);

    localparam int unsigned RunW = 4;
    localparam int unsigned NumCh = 3;

    // Channel order in all packed vectors: [2]=A, [1]=B, [0]=index
    logic [NumCh-1:0]           sync1_q, sync2_q;
    logic [15:0]                presc_q, presc_d;
    logic [15:0]                div;
    logic                       tick;
    logic [NumCh-1:0][RunW-1:0] run_q, run_d;
    logic [NumCh-1:0]           filt_q, filt_d;
    logic                       illegal;
    logic                       idx_rise;
    logic                       index_strobe_q, index_strobe_d;
    logic                       err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]           err_count_q, err_count_d;
    logic                       err_sticky_q, err_sticky_d;

    always_comb begin
        div     = (clk_div_i == 16'd0) ? 16'd1 : clk_div_i;
        // >= rather than == so lowering the divider below the count wraps promptly
        tick    = (presc_q >= div - 16'd1);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    always_comb begin
        run_d  = run_q;
        filt_d = filt_q;
        for (int i = 0; i < NumCh; i++) begin
            if (tick) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (run_q[i] == RunW'(FILT_LEN - 1)) begin
                        filt_d[i] = sync2_q[i];
                        run_d[i]  = '0;
                    end else begin
                        run_d[i] = run_q[i] + 1'b1;
                    end
                end else begin
                    run_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        illegal      = (filt_d[2] != filt_q[2]) && (filt_d[1] != filt_q[1]);
        err_pulse_d  = illegal;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (illegal) begin
            // A coincident clear loses to the event: the new error is still counted
            err_sticky_d = 1'b1;
            if (err_clr_i) begin
                err_count_d = ERR_W'(1);
            end else if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end else if (err_clr_i) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end
    end

    assign idx_rise = filt_d[0] & ~filt_q[0];

`ifdef QUAD_ENC_FILT_INDEX_GATE_EN
    assign index_strobe_d = idx_rise && (filt_d[2:1] == index_gate_i);
`else
    logic unused_index_gate;
    assign unused_index_gate = ^index_gate_i;
    assign index_strobe_d    = idx_rise;
`endif

    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            presc_q        <= '0;
            run_q          <= '0;
            filt_q         <= '0;
            index_strobe_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= '0;
            err_sticky_q   <= 1'b0;
        end else begin
            sync1_q        <= {quadA_i, quadB_i, index_i};
            sync2_q        <= sync1_q;
            presc_q        <= presc_d;
            run_q          <= run_d;
            filt_q         <= filt_d;
            index_strobe_q <= index_strobe_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
            err_sticky_q   <= err_sticky_d;
        end
    end

    assign quadA        = filt_q[2];
    assign quadB        = filt_q[1];
    assign index_strobe = index_strobe_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign err_sticky   = err_sticky_q;

endmodule
